// File: rtl/srsystem_pkg.sv
// Shared types and constants for the parametrised serial receiver.
package srsystem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned ERR_W   = 3;
    localparam int unsigned ERR_OVR = 2;
    localparam int unsigned ERR_FRM = 1;
    localparam int unsigned ERR_PAR = 0;

endpackage

// File: rtl/srsystem_rx_param_if.sv
// Receiver-side bundle: serial line and enable in, word/flags out with ready/ack handshake.
interface srsystem_rx_param_if #(
    parameter int unsigned DATA_W = 8
);
    logic              en;
    logic              rx;
    logic              ack;
    logic              dry;
    logic [2:0]        err;
    logic [DATA_W-1:0] q;

    modport slave (
        input  en,
        input  rx,
        input  ack,
        output dry,
        output err,
        output q
    );

    modport master (
        output en,
        output rx,
        output ack,
        input  dry,
        input  err,
        input  q
    );
endinterface

// File: rtl/srsystem_bit_timer.sv
// Free-running bit-period counter with synchronous clear, half-bit and wrap strobes.
module srsystem_bit_timer #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic half_c,
    output logic wrap_c
);
    localparam int unsigned TMR_W = $clog2(CLK_DIV);

    logic [TMR_W-1:0] cnt;

    assign half_c = (cnt == TMR_W'(CLK_DIV / 2 - 1));
    assign wrap_c = (cnt == TMR_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || wrap_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TMR_W'(1);
        end
    end
endmodule

// File: rtl/srsystem_rx_param.sv
// Parametrised async serial receiver: synchroniser, framing FSM, shift/parity datapath
// and a ready/ack output register with sticky error flags and overrun detection.
module srsystem_rx_param
    import srsystem_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CLK_DIV     = 16,
    parameter int unsigned PARITY_MODE = 1,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    srsystem_rx_param_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    if (DATA_W < 5 || DATA_W > 16) begin : g_bad_data_w
        $error("srsystem_rx_param: DATA_W must be in 5..16");
    end
    if (CLK_DIV < 4 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
        $error("srsystem_rx_param: CLK_DIV must be even and >= 4");
    end
    if (PARITY_MODE > PAR_EVEN) begin : g_bad_parity
        $error("srsystem_rx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("srsystem_rx_param: STOP_BITS must be 1 or 2");
    end

    state_t             state;
    state_t             state_nxt;
    logic               rx_m;
    logic               rxs;
    logic               rxs_d;
    logic               half_c;
    logic               wrap_c;
    logic               tmr_clr_c;
    logic               cnt_clr_c;
    logic               cnt_inc_c;
    logic               shift_c;
    logic               par_chk_c;
    logic               stop_chk_c;
    logic               flags_clr_c;
    logic               deliver_c;
    logic               par_bad_c;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shreg;
    logic               par_acc;
    logic               par_err;
    logic               frm_err;
    logic               dry_r;
    logic [ERR_W-1:0]   err_r;
    logic [DATA_W-1:0]  q_r;

    // Two-flop synchroniser plus one history flop for start-edge detection; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m  <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            rx_m  <= bus.rx;
            rxs   <= rx_m;
            rxs_d <= rxs;
        end
    end

    srsystem_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst),
        .clr    (tmr_clr_c),
        .half_c (half_c),
        .wrap_c (wrap_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Restarting the timer at the half-bit check puts every later wrap strobe at mid-bit.
    always_comb begin
        state_nxt   = state;
        tmr_clr_c   = 1'b0;
        cnt_clr_c   = 1'b0;
        cnt_inc_c   = 1'b0;
        shift_c     = 1'b0;
        par_chk_c   = 1'b0;
        stop_chk_c  = 1'b0;
        flags_clr_c = 1'b0;
        deliver_c   = 1'b0;
        if (!bus.en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs && rxs_d) begin
                        state_nxt   = START;
                        tmr_clr_c   = 1'b1;
                        cnt_clr_c   = 1'b1;
                        flags_clr_c = 1'b1;
                    end
                end
                START: begin
                    if (half_c) begin
                        if (rxs) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DATA;
                            tmr_clr_c = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (wrap_c) begin
                        shift_c = 1'b1;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            cnt_clr_c = 1'b1;
                            state_nxt = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                        end else begin
                            cnt_inc_c = 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (wrap_c) begin
                        par_chk_c = 1'b1;
                        state_nxt = STOP;
                    end
                end
                STOP: begin
                    if (wrap_c) begin
                        stop_chk_c = 1'b1;
                        if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
                            cnt_clr_c = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            cnt_inc_c = 1'b1;
                        end
                    end
                end
                DONE: begin
                    deliver_c = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign par_bad_c = (PARITY_MODE == PAR_EVEN) ? (par_acc ^ rxs) : ~(par_acc ^ rxs);

    // Frame datapath: LSB-first shift, running parity, per-frame error flags, bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            par_acc <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            bit_cnt <= '0;
        end else begin
            if (flags_clr_c) begin
                par_acc <= 1'b0;
                par_err <= 1'b0;
                frm_err <= 1'b0;
            end
            if (shift_c) begin
                shreg   <= {rxs, shreg[DATA_W-1:1]};
                par_acc <= par_acc ^ rxs;
            end
            if (par_chk_c) begin
                par_err <= par_bad_c;
            end
            if (stop_chk_c && !rxs) begin
                frm_err <= 1'b1;
            end
            if (cnt_clr_c) begin
                bit_cnt <= '0;
            end else if (cnt_inc_c) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // An unacknowledged word is never overwritten; a colliding frame only raises overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dry_r <= 1'b0;
            err_r <= '0;
            q_r   <= '0;
        end else if (deliver_c) begin
            if (!dry_r || bus.ack) begin
                q_r   <= shreg;
                err_r <= {1'b0, frm_err, par_err};
                dry_r <= 1'b1;
            end else begin
                err_r[ERR_OVR] <= 1'b1;
            end
        end else if (bus.ack && dry_r) begin
            dry_r <= 1'b0;
            err_r <= '0;
        end
    end

    assign bus.dry = dry_r;
    assign bus.err = err_r;
    assign bus.q   = q_r;

endmodule
